vram_console_writer: RTL and testbench

VRAM_CONSOLE_WRITER -- requirements
Module: vram_console_writer

---
 rtl/vram_console_pkg.sv | 40 ++++
 rtl/vram_console_writer_if.sv | 18 +
 rtl/vram_console_writer_cursor.sv | 52 +++++
 rtl/vram_console_writer.sv | 189 ++++++++++++++++++
 tb/tb_vram_console_writer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_console_pkg.sv
// Shared definitions for the VRAM text console writer.
//   - default screen geometry (COLS_DEF x ROWS_DEF) and VRAM depth
//   - control-code constants recognised in the character stream
//   - FSM state enum and the cursor operation enum
//   - cell_addr(): linear VRAM address of a (row, col) text cell
package vram_console_pkg;

  localparam int COLS_DEF   = 60;
  localparam int ROWS_DEF   = 17;
  localparam int VRAM_DEPTH = 1024;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_LINECLR
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADV,   // printable byte written: step right, wrap to next row
    OP_CR,
    OP_LF,
    OP_BS,
    OP_HOME
  } cur_op_e;

  // Row-major cell address; the screen always fits inside 1024 bytes.
  function automatic logic [9:0] cell_addr(input logic [4:0] row,
                                           input logic [5:0] col,
                                           input int         cols);
    return 10'(int'(row) * cols + int'(col));
  endfunction

endpackage

// File: rtl/vram_console_writer_if.sv
// Character-stream and VRAM write-port bundle for the console writer.
//   in_valid/in_data/in_ready : byte stream into the writer (valid/ready)
//   v_ada/v_cea/v_din         : VRAM write port driven by the writer
// master = the side feeding characters and observing VRAM writes,
// slave  = the console writer itself.
interface vram_console_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [9:0] v_ada;
  logic       v_cea;
  logic [7:0] v_din;

  modport master (output in_valid, in_data,
                  input  in_ready, v_ada, v_cea, v_din);
  modport slave  (input  in_valid, in_data,
                  output in_ready, v_ada, v_cea, v_din);
endinterface

// File: rtl/vram_console_writer_cursor.sv
// console_cursor: purely combinational cursor arithmetic.
//   op            : operation applied this cycle (OP_NONE keeps position)
//   col / row     : current cursor
//   nxt_col / nxt_row : cursor after the operation
// Column advance wraps into the next row; the row wraps ROWS-1 -> 0.
// Backspace at column 0 leaves the cursor untouched.
module console_cursor
  import vram_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  cur_op_e    op,
  input  logic [5:0] col,
  input  logic [4:0] row,
  output logic [5:0] nxt_col,
  output logic [4:0] nxt_row
);

  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  logic [4:0] row_inc;

  always_comb begin
    row_inc = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
    nxt_col = col;
    nxt_row = row;
    case (op)
      OP_ADV: begin
        if (col == COL_LAST) begin
          nxt_col = 6'd0;
          nxt_row = row_inc;
        end else begin
          nxt_col = col + 6'd1;
        end
      end
      OP_CR:   nxt_col = 6'd0;
      OP_LF: begin
        nxt_col = 6'd0;
        nxt_row = row_inc;
      end
      OP_BS:   if (col != 6'd0) nxt_col = col - 6'd1;
      OP_HOME: begin
        nxt_col = 6'd0;
        nxt_row = 5'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vram_console_writer.sv
// vram_console_writer: turns a byte stream into writes on a 1024x8 text VRAM.
//   MEMORY_CLK, rst_n (async, active low)
//   in_valid/in_data/in_ready : character stream, accepted only in IDLE
//   v_ada/v_cea/v_din         : registered VRAM write port, one byte per pulse
//   busy                      : full-screen or line clear in progress
//   cursor_col/cursor_row     : current text cursor
// Control codes: BS 0x08, LF 0x0A, FF 0x0C (full clear), CR 0x0D.
// Optional feature: define VRAM_LINE_CLEAR_EN to blank every row the cursor
// moves onto (LINECLR state). Without it, new rows keep their old content.
module vram_console_writer
  import vram_console_pkg::*;
#(
  parameter int         COLS       = COLS_DEF,
  parameter int         ROWS       = ROWS_DEF,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic       MEMORY_CLK,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [9:0] v_ada,
  output logic       v_cea,
  output logic [7:0] v_din,
  output logic       busy,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam logic [9:0] LAST_ADDR = 10'(VRAM_DEPTH - 1);

  state_e     state_q, state_d;
  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [9:0] v_ada_q, v_ada_d;
  logic       v_cea_q, v_cea_d;
  logic [7:0] v_din_q, v_din_d;
`ifdef VRAM_LINE_CLEAR_EN
  // Set when a printable byte wrapped the cursor onto a new row; the line
  // clear then follows the character write.
  logic       lc_pend_q, lc_pend_d;
`endif

  cur_op_e    op;
  logic [5:0] nxt_col;
  logic [4:0] nxt_row;

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .op      (op),
    .col     (col_q),
    .row     (row_q),
    .nxt_col (nxt_col),
    .nxt_row (nxt_row)
  );

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      col_q     <= 6'd0;
      row_q     <= 5'd0;
      v_ada_q   <= 10'd0;
      v_cea_q   <= 1'b0;
      v_din_q   <= 8'd0;
`ifdef VRAM_LINE_CLEAR_EN
      lc_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      v_ada_q   <= v_ada_d;
      v_cea_q   <= v_cea_d;
      v_din_q   <= v_din_d;
`ifdef VRAM_LINE_CLEAR_EN
      lc_pend_q <= lc_pend_d;
`endif
    end
  end

  // VRAM outputs are registered: a write decided on edge N is on the port
  // for the whole cycle after N. Clears therefore run in a state whose
  // every cycle carries one write, and leave the moment the last address
  // is on the bus.
  always_comb begin
    state_d   = state_q;
    op        = OP_NONE;
    v_cea_d   = 1'b0;
    v_ada_d   = v_ada_q;
    v_din_d   = v_din_q;
`ifdef VRAM_LINE_CLEAR_EN
    lc_pend_d = lc_pend_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        if (v_cea_q && v_ada_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          // No write on the bus yet means the sweep starts (after reset).
          v_cea_d = 1'b1;
          v_ada_d = v_cea_q ? v_ada_q + 10'd1 : 10'd0;
          v_din_d = CLEAR_CHAR;
        end
      end
      ST_IDLE: begin
        if (in_valid) begin
          case (in_data)
            CH_CR: op = OP_CR;
            CH_LF: begin
              op = OP_LF;
`ifdef VRAM_LINE_CLEAR_EN
              state_d = ST_LINECLR;
              v_cea_d = 1'b1;
              v_ada_d = cell_addr(nxt_row, 6'd0, COLS);
              v_din_d = CLEAR_CHAR;
`endif
            end
            CH_BS: begin
              if (col_q != 6'd0) begin
                op      = OP_BS;
                state_d = ST_WRITE;
                v_cea_d = 1'b1;
                v_ada_d = cell_addr(row_q, nxt_col, COLS);
                v_din_d = CLEAR_CHAR;
              end
            end
            CH_FF: begin
              // First clear write goes out alongside the FF acceptance.
              op      = OP_HOME;
              state_d = ST_CLEAR;
              v_cea_d = 1'b1;
              v_ada_d = 10'd0;
              v_din_d = CLEAR_CHAR;
            end
            default: begin
              op      = OP_ADV;
              state_d = ST_WRITE;
              v_cea_d = 1'b1;
              v_ada_d = cell_addr(row_q, col_q, COLS);
              v_din_d = in_data;
`ifdef VRAM_LINE_CLEAR_EN
              lc_pend_d = (nxt_row != row_q);
`endif
            end
          endcase
        end
      end
      ST_WRITE: begin
`ifdef VRAM_LINE_CLEAR_EN
        if (lc_pend_q) begin
          // Cursor already sits on the new row.
          lc_pend_d = 1'b0;
          state_d   = ST_LINECLR;
          v_cea_d   = 1'b1;
          v_ada_d   = cell_addr(row_q, 6'd0, COLS);
          v_din_d   = CLEAR_CHAR;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_LINECLR: begin
`ifdef VRAM_LINE_CLEAR_EN
        if (v_ada_q == cell_addr(row_q, 6'(COLS - 1), COLS)) begin
          state_d = ST_IDLE;
        end else begin
          v_cea_d = 1'b1;
          v_ada_d = v_ada_q + 10'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_CLEAR;
    endcase
    col_d = nxt_col;
    row_d = nxt_row;
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_CLEAR) || (state_q == ST_LINECLR);
  assign v_ada      = v_ada_q;
  assign v_cea      = v_cea_q;
  assign v_din      = v_din_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_vram_console_writer.sv
// Randomised self-checking bench for vram_console_writer. A screen-level
// model (cursor position plus the list of VRAM writes it should cause) is
// advanced for every accepted byte; observed writes are logged and compared.
module tb_vram_console_writer;

  localparam int COLS = 60;
  localparam int ROWS = 17;
`ifdef VRAM_LINE_CLEAR_EN
  localparam int LC = 1;
`else
  localparam int LC = 0;
`endif

  logic       MEMORY_CLK = 1'b0;
  logic       rst_n      = 1'b0;
  logic       busy;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;

  vram_console_writer_if bus ();

  vram_console_writer dut (
    .MEMORY_CLK (MEMORY_CLK),
    .rst_n      (rst_n),
    .in_valid   (bus.in_valid),
    .in_data    (bus.in_data),
    .in_ready   (bus.in_ready),
    .v_ada      (bus.v_ada),
    .v_cea      (bus.v_cea),
    .v_din      (bus.v_din),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 MEMORY_CLK = ~MEMORY_CLK;

  typedef struct {int a; int d; int c;} wr_t;
  wr_t wr_q[$];
  wr_t exp_q[$];

  int cyc = 0, busy_cyc = 0, n_chk = 0, n_fail = 0;
  int mcol = 0, mrow = 0, last_acc = 0;

  always @(posedge MEMORY_CLK) cyc <= cyc + 1;

  always @(negedge MEMORY_CLK) begin
    if (rst_n && bus.v_cea === 1'b1)
      wr_q.push_back('{a: int'(bus.v_ada), d: int'(bus.v_din), c: cyc});
    if (busy === 1'b1) busy_cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- screen model ----------------
  function automatic void m_push(input int a, input int d);
    exp_q.push_back('{a: a, d: d, c: 0});
  endfunction

  function automatic void m_newrow();
    mrow = (mrow + 1) % ROWS;
    if (LC != 0)
      for (int i = 0; i < COLS; i++) m_push(mrow * COLS + i, 'h20);
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    case (b)
      8'h0D: mcol = 0;
      8'h0A: begin mcol = 0; m_newrow(); end
      8'h08: if (mcol > 0) begin mcol--; m_push(mrow * COLS + mcol, 'h20); end
      8'h0C: begin
        for (int i = 0; i < 1024; i++) m_push(i, 'h20);
        mcol = 0; mrow = 0;
      end
      default: begin
        m_push(mrow * COLS + mcol, int'(b));
        mcol++;
        if (mcol == COLS) begin mcol = 0; m_newrow(); end
      end
    endcase
  endfunction

  function automatic int first_diff();
    int n;
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wr_q[i].a != exp_q[i].a || wr_q[i].d != exp_q[i].d) return i;
    return -1;
  endfunction

  function automatic void clear_logs();
    wr_q.delete();
    exp_q.delete();
  endfunction

  // ---------------- drivers (always entered at a negedge) ----------------
  // Leaves in_valid high so consecutive calls stream back to back.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(negedge MEMORY_CLK); n++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: byte %02h in_ready=%b required 1", b, bus.in_ready);
    end else begin
      last_acc = cyc + 1;
      m_byte(b);
    end
    @(negedge MEMORY_CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.in_valid = 1'b0;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(negedge MEMORY_CLK); n++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int rel, idx;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; rst_n = 1'b0;
    repeat (3) @(negedge MEMORY_CLK);
    n_chk++; if (bus.v_cea !== 1'b0) begin n_fail++; $display("FAIL rst_v_cea: got %b expected 0", bus.v_cea); end
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", busy); end
    n_chk++; if ({bus.v_ada, bus.v_din} !== 18'd0) begin n_fail++; $display("FAIL rst_bus: got ada=%0d din=%02h expected 0/00", bus.v_ada, bus.v_din); end
    n_chk++; if ({cursor_col, cursor_row} !== 11'd0) begin n_fail++; $display("FAIL rst_cursor: got (%0d,%0d) expected (0,0)", cursor_col, cursor_row); end
    clear_logs(); mcol = 0; mrow = 0;
    for (int i = 0; i < 1024; i++) m_push(i, 'h20);
    rst_n = 1'b1; rel = cyc;
    wait_idle();
    n_chk++; if (wr_q.size() != 1024) begin n_fail++; $display("FAIL rst_clear_count: got %0d expected 1024", wr_q.size()); end
    idx = first_diff();
    n_chk++; if (idx != -1) begin n_fail++; $display("FAIL rst_clear_seq: at %0d got %0d/%02h expected %0d/%02h", idx, wr_q[idx].a, wr_q[idx].d, exp_q[idx].a, exp_q[idx].d); end
    if (wr_q.size() > 0) begin
      n_chk++; if (wr_q[0].c != rel + 1) begin n_fail++; $display("FAIL rst_first_edge: first write cycle %0d expected %0d", wr_q[0].c, rel + 1); end
    end
    n_chk++; if ({cursor_col, cursor_row} !== 11'd0) begin n_fail++; $display("FAIL rst_idle_cursor: got (%0d,%0d) expected (0,0)", cursor_col, cursor_row); end
  endtask

  task automatic test_stream_a();
    int first = 0, idx;
    int aq[$];
    clear_logs();
    for (int i = 0; i < 61; i++) begin
      send(8'h41);
      if (i == 0) first = last_acc;
    end
    wait_idle();
    n_chk++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    idx = first_diff();
    n_chk++; if (idx != -1) begin n_fail++; $display("FAIL stream_seq: at %0d got %0d/%02h expected %0d/%02h", idx, wr_q[idx].a, wr_q[idx].d, exp_q[idx].a, exp_q[idx].d); end
    foreach (wr_q[i]) if (wr_q[i].d == 'h41) aq.push_back(wr_q[i].a);
    n_chk++;
    if (aq.size() != 61) begin n_fail++; $display("FAIL stream_a_writes: got %0d expected 61", aq.size()); end
    else begin
      n_chk++; if (aq[59] != 59) begin n_fail++; $display("FAIL stream_addr60th: got %0d expected 59", aq[59]); end
      n_chk++; if (aq[60] != 60) begin n_fail++; $display("FAIL stream_addr61st: got %0d expected 60", aq[60]); end
    end
    if (wr_q.size() > 0) begin
      n_chk++; if (wr_q[0].c != first) begin n_fail++; $display("FAIL stream_latency: write cycle %0d expected %0d", wr_q[0].c, first); end
    end
    n_chk++; if (last_acc - first != 2 * 60 + LC * COLS) begin n_fail++; $display("FAIL stream_throughput: span %0d expected %0d", last_acc - first, 2 * 60 + LC * COLS); end
    n_chk++; if (cursor_col !== 6'd1 || cursor_row !== 5'd1) begin n_fail++; $display("FAIL stream_cursor: got (%0d,%0d) expected (1,1)", cursor_col, cursor_row); end
  endtask

  task automatic test_lf_wrap();
    int idx;
    send(8'h0D);
    repeat (15) send(8'h0A);
    repeat (5) send(8'h41);
    wait_idle();
    n_chk++; if (cursor_col !== 6'd5 || cursor_row !== 5'd16) begin n_fail++; $display("FAIL lf_setup_cursor: got (%0d,%0d) expected (5,16)", cursor_col, cursor_row); end
    clear_logs();
    send(8'h0A);
    wait_idle();
    n_chk++; if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin n_fail++; $display("FAIL lf_wrap_cursor: got (%0d,%0d) expected (0,0)", cursor_col, cursor_row); end
    n_chk++; if (wr_q.size() != LC * 60) begin n_fail++; $display("FAIL lf_wrap_count: got %0d expected %0d", wr_q.size(), LC * 60); end
    idx = first_diff();
    n_chk++; if (idx != -1) begin n_fail++; $display("FAIL lf_wrap_seq: at %0d got %0d/%02h expected %0d/%02h", idx, wr_q[idx].a, wr_q[idx].d, exp_q[idx].a, exp_q[idx].d); end
  endtask

  task automatic test_backspace();
    send(8'h0A); send(8'h0A);
    repeat (3) send(8'h42);
    wait_idle();
    clear_logs();
    send(8'h08);
    wait_idle();
    n_chk++;
    if (wr_q.size() != 1) begin n_fail++; $display("FAIL bs_count: got %0d expected 1", wr_q.size()); end
    else if (wr_q[0].a != 122 || wr_q[0].d != 'h20) begin n_fail++; $display("FAIL bs_write: got %0d/%02h expected 122/20", wr_q[0].a, wr_q[0].d); end
    n_chk++; if (cursor_col !== 6'd2 || cursor_row !== 5'd2) begin n_fail++; $display("FAIL bs_cursor: got (%0d,%0d) expected (2,2)", cursor_col, cursor_row); end
    clear_logs();
    send(8'h0D); send(8'h08);
    wait_idle();
    n_chk++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL bs_col0_count: got %0d expected 0", wr_q.size()); end
    n_chk++; if (cursor_col !== 6'd0 || cursor_row !== 5'd2) begin n_fail++; $display("FAIL bs_col0_cursor: got (%0d,%0d) expected (0,2)", cursor_col, cursor_row); end
  endtask

  task automatic test_ff_midstream();
    int idx;
    send(8'h0D);
    wait_idle();
    clear_logs(); busy_cyc = 0;
    for (int i = 0; i < 5; i++) send(8'($urandom_range(8'h21, 8'h7e)));
    send(8'h0C);
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ff_ready_drop: got %b expected 0", bus.in_ready); end
    for (int i = 0; i < 5; i++) send(8'($urandom_range(8'h21, 8'h7e)));
    wait_idle();
    n_chk++; if (busy_cyc != 1024) begin n_fail++; $display("FAIL ff_busy_cycles: got %0d expected 1024", busy_cyc); end
    n_chk++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ff_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    idx = first_diff();
    n_chk++; if (idx != -1) begin n_fail++; $display("FAIL ff_seq: at %0d got %0d/%02h expected %0d/%02h", idx, wr_q[idx].a, wr_q[idx].d, exp_q[idx].a, exp_q[idx].d); end
    n_chk++; if (int'(cursor_col) != mcol || int'(cursor_row) != mrow) begin n_fail++; $display("FAIL ff_cursor: got (%0d,%0d) expected (%0d,%0d)", cursor_col, cursor_row, mcol, mrow); end
  endtask

  task automatic test_random();
    int idx, r;
    logic [7:0] b;
    clear_logs();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h5A;
      end else if (r < 80) b = 8'h0D;
      else if (r < 90) b = 8'h0A;
      else b = 8'h08;
      send(b);
    end
    wait_idle();
    n_chk++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    idx = first_diff();
    n_chk++; if (idx != -1) begin n_fail++; $display("FAIL rand_seq: at %0d got %0d/%02h expected %0d/%02h", idx, wr_q[idx].a, wr_q[idx].d, exp_q[idx].a, exp_q[idx].d); end
    n_chk++; if (int'(cursor_col) != mcol || int'(cursor_row) != mrow) begin n_fail++; $display("FAIL rand_cursor: got (%0d,%0d) expected (%0d,%0d)", cursor_col, cursor_row, mcol, mrow); end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0, rel, idx;
    clear_logs();
    send(8'h0C);
    bus.in_valid = 1'b0;
    while (wr_q.size() < 500 && n < 2000) begin @(negedge MEMORY_CLK); n++; end
    n_chk++; if (wr_q.size() < 500) begin n_fail++; $display("FAIL midclr_progress: got %0d writes expected 500", wr_q.size()); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.v_cea !== 1'b0) begin n_fail++; $display("FAIL midclr_v_cea: got %b expected 0", bus.v_cea); end
    n_chk++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midclr_flags: got busy=%b in_ready=%b expected 1/0", busy, bus.in_ready); end
    n_chk++; if (bus.v_ada !== 10'd0) begin n_fail++; $display("FAIL midclr_v_ada: got %0d expected 0", bus.v_ada); end
    @(negedge MEMORY_CLK);
    clear_logs(); mcol = 0; mrow = 0;
    for (int i = 0; i < 1024; i++) m_push(i, 'h20);
    rst_n = 1'b1; rel = cyc;
    wait_idle();
    if (wr_q.size() > 0) begin
      n_chk++; if (wr_q[0].a != 0 || wr_q[0].c != rel + 1) begin n_fail++; $display("FAIL midclr_restart: got addr %0d cycle %0d expected 0 cycle %0d", wr_q[0].a, wr_q[0].c, rel + 1); end
    end
    n_chk++; if (wr_q.size() != 1024) begin n_fail++; $display("FAIL midclr_count: got %0d expected 1024", wr_q.size()); end
    idx = first_diff();
    n_chk++; if (idx != -1) begin n_fail++; $display("FAIL midclr_seq: at %0d got %0d/%02h expected %0d/%02h", idx, wr_q[idx].a, wr_q[idx].d, exp_q[idx].a, exp_q[idx].d); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge MEMORY_CLK);
    test_reset();
    test_stream_a();
    test_lf_wrap();
    test_backspace();
    test_ff_midstream();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
